alu_ctrl_seq: RTL

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with request/result handshake and multi-cycle
// latency sequencing for multiply/divide (MDU) operations.
module alu_ctrl_seq #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 32,
    parameter bit CTZ_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_ctrl,
    output logic       mdu_sel,
    output logic [2:0] mdu_op,
    output logic       busy
);

    // state | meaning
    // IDLE  | no op held, ready to accept
    // BUSY  | MDU op counting down its latency
    // VALID | result presented, waiting for consumer
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        VALID = 2'b10
    } state_t;

    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_MDU = 7'b0000001;

    // Counter preload is latency-2: one cycle is spent entering BUSY and
    // one leaving it, so the result lands exactly L cycles after acceptance.
    localparam bit        MUL_LONG = (MUL_CYCLES >= 2);
    localparam bit        DIV_LONG = (DIV_CYCLES >= 2);
    localparam logic [5:0] MUL_LOAD = MUL_LONG ? 6'(MUL_CYCLES - 2) : 6'd0;
    localparam logic [5:0] DIV_LOAD = DIV_LONG ? 6'(DIV_CYCLES - 2) : 6'd0;

    state_t     state, state_d;
    logic [5:0] cnt, cnt_d;
    logic       capture;
    logic       xfer_in;

    logic [3:0] dec_ctrl;
    logic       dec_mdu;
    logic       dec_long;
    logic [5:0] dec_load;

    // Combinational decode of the incoming request.
    always_comb begin
        dec_ctrl = 4'b0000;
        dec_mdu  = 1'b0;
        case (alu_op)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: dec_ctrl = 4'b0110;
                    3'b100, 3'b101: dec_ctrl = 4'b0111;
                    3'b110, 3'b111: dec_ctrl = 4'b1000;
                    default:        dec_ctrl = 4'b0000;
                endcase
            end
            2'b10: begin
                if (funct7 == F7_MDU) begin
                    dec_ctrl = 4'b1110;
                    dec_mdu  = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  dec_ctrl = (funct7 == F7_ALT) ? 4'b0110 : 4'b0010;
                        3'b001:  dec_ctrl = 4'b0001;
                        3'b010:  dec_ctrl = 4'b0111;
                        3'b011:  dec_ctrl = 4'b1000;
                        3'b100:  dec_ctrl = 4'b0100;
                        3'b101:  dec_ctrl = (funct7 == F7_ALT) ? 4'b0101 : 4'b0011;
                        3'b110:  dec_ctrl = 4'b0000;
                        default: dec_ctrl = 4'b1100;
                    endcase
                end
            end
            default: begin
                if (CTZ_EN && funct3 == 3'b101 && funct7 == F7_MDU)
                    dec_ctrl = 4'b1111;
            end
        endcase
        dec_long = dec_mdu && (funct3[2] ? DIV_LONG : MUL_LONG);
        dec_load = funct3[2] ? DIV_LOAD : MUL_LOAD;
    end

    // Next-state, counter and handshake logic; flush overrides everything.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        in_ready = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
            VALID: in_ready = out_ready;
            BUSY: begin
                if (cnt == 6'd0) state_d = VALID;
                else             cnt_d   = cnt - 6'd1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) in_ready = 1'b0;
        xfer_in = in_valid && in_ready;
        if (state == VALID && out_ready && !xfer_in)
            state_d = IDLE;
        if (xfer_in) begin
            capture = 1'b1;
            if (dec_long) begin
                state_d = BUSY;
                cnt_d   = dec_load;
            end else begin
                state_d = VALID;
                cnt_d   = 6'd0;
            end
        end
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Result registers: loaded on acceptance, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl <= 4'b0000;
            mdu_sel  <= 1'b0;
            mdu_op   <= 3'b000;
        end else if (flush) begin
            alu_ctrl <= 4'b0000;
            mdu_sel  <= 1'b0;
            mdu_op   <= 3'b000;
        end else if (capture) begin
            alu_ctrl <= dec_ctrl;
            mdu_sel  <= dec_mdu;
            mdu_op   <= dec_mdu ? funct3 : 3'b000;
        end
    end

    assign out_valid = (state == VALID);
    assign busy      = (state == BUSY);

endmodule
